// File: rtl/pc_next_fetch_if.sv
// Fetch-stage bundle: PC register loop, instruction-memory handshake, redirect/stall inputs and IF/ID outputs.
// The master modport belongs to pc_next_fetch; the slave modport belongs to the surrounding pipeline/memory.
interface pc_next_fetch_if;
    logic [31:0] currentPC;
    logic [31:0] newPC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        id_stall;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        fetch_fault;

    modport master (
        input  currentPC, imem_ack, imem_rdata, redirect_valid, redirect_target, id_stall,
        output newPC, imem_req, imem_addr, ifid_valid, ifid_pc, ifid_instr, fetch_fault
    );

    modport slave (
        output currentPC, imem_ack, imem_rdata, redirect_valid, redirect_target, id_stall,
        input  newPC, imem_req, imem_addr, ifid_valid, ifid_pc, ifid_instr, fetch_fault
    );
endinterface

// File: rtl/pc_next_fetch.sv
// Instruction-fetch stage: drives next-PC, issues imem requests at currentPC and loads IF/ID.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirects raise a sticky fetch_fault and halt fetch.
module pc_next_fetch #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter logic [31:0] PC_STEP   = 32'd4
) (
    input  logic           clk,
    input  logic           rst,
    pc_next_fetch_if.master bus
);

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {S_REQ, S_DROP, S_HOLD, S_HALT} state_e;
`else
    typedef enum logic [1:0] {S_REQ, S_DROP, S_HOLD} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        fault_q, fault_d;

    logic [31:0] target;
    logic        bad_target;
    logic [31:0] pc_seq;
    logic        have_load;
    logic [31:0] load_pc;
    logic [31:0] load_instr;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target     = bus.redirect_target;
    assign bad_target = |bus.redirect_target[1:0];
`else
    assign target     = {bus.redirect_target[31:2], 2'b00};
    assign bad_target = 1'b0;
`endif

    // Wraps naturally modulo 2^32.
    assign pc_seq = bus.currentPC + PC_STEP;

    always_comb begin
        state_d       = state_q;
        skid_pc_d     = skid_pc_q;
        skid_instr_d  = skid_instr_q;
        pend_target_d = pend_target_q;
        fault_d       = fault_q;
        bus.newPC     = bus.currentPC;
        bus.imem_req  = 1'b0;
        have_load     = 1'b0;
        load_pc       = bus.currentPC;
        load_instr    = bus.imem_rdata;

        case (state_q)
            S_REQ: begin
                bus.imem_req = 1'b1;
                if (bus.redirect_valid) begin
                    if (bad_target) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                        fault_d = 1'b1;
                        state_d = S_HALT;
`endif
                    end else if (bus.imem_ack) begin
                        bus.newPC = target;
                    end else begin
                        pend_target_d = target;
                        state_d       = S_DROP;
                    end
                end else if (bus.imem_ack) begin
                    bus.newPC  = pc_seq;
                    have_load  = 1'b1;
                    if (bus.id_stall) begin
                        skid_pc_d    = bus.currentPC;
                        skid_instr_d = bus.imem_rdata;
                        state_d      = S_HOLD;
                    end
                end
            end

            S_DROP: begin
                // The outstanding request must complete before the new target can be issued.
                bus.imem_req = 1'b1;
                if (bus.redirect_valid) begin
                    if (bad_target) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                        fault_d = 1'b1;
                        state_d = S_HALT;
`endif
                    end else if (bus.imem_ack) begin
                        bus.newPC = target;
                        state_d   = S_REQ;
                    end else begin
                        pend_target_d = target;
                    end
                end else if (bus.imem_ack) begin
                    bus.newPC = pend_target_q;
                    state_d   = S_REQ;
                end
            end

            S_HOLD: begin
                have_load  = 1'b1;
                load_pc    = skid_pc_q;
                load_instr = skid_instr_q;
                if (bus.redirect_valid) begin
                    if (bad_target) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                        fault_d = 1'b1;
                        state_d = S_HALT;
`endif
                    end else begin
                        bus.newPC = target;
                        state_d   = S_REQ;
                    end
                end else if (!bus.id_stall) begin
                    state_d = S_REQ;
                end
            end

            default: begin
`ifdef FETCH_MISALIGN_CHECK_EN
                state_d = S_HALT;
`else
                state_d = S_REQ;
`endif
            end
        endcase
    end

    // IF/ID: redirect flushes, then stall holds, then load or bubble.
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        if (bus.redirect_valid) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (bus.id_stall) begin
            ifid_valid_d = ifid_valid_q;
        end else if (have_load) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = load_pc;
            ifid_instr_d = load_instr;
        end else begin
            ifid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            skid_pc_q     <= 32'd0;
            skid_instr_q  <= 32'd0;
            pend_target_q <= 32'd0;
            ifid_valid_q  <= 1'b0;
            ifid_pc_q     <= 32'd0;
            ifid_instr_q  <= NOP_INSTR;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            skid_pc_q     <= skid_pc_d;
            skid_instr_q  <= skid_instr_d;
            pend_target_q <= pend_target_d;
            ifid_valid_q  <= ifid_valid_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_instr_q  <= ifid_instr_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.imem_addr  = bus.currentPC;
    assign bus.ifid_valid = ifid_valid_q;
    assign bus.ifid_pc    = ifid_pc_q;
    assign bus.ifid_instr = ifid_instr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign bus.fetch_fault = fault_q;
`else
    assign bus.fetch_fault = 1'b0;
    logic unused_fault;
    assign unused_fault = fault_q;
`endif

endmodule

// File: doc/pc_next_fetch.md
# pc_next_fetch

Instruction-fetch stage that closes the loop around the PC register. It drives the PC register's next-PC input, issues instruction-memory requests at the current PC, and loads the IF/ID pipeline register. It also absorbs decode stalls, execute-stage redirects and variable memory latency. The PC register has no enable, so this block recirculates the current PC whenever fetch must not advance.

## Interface
- `NOP_INSTR`, default 32'h00000013: instruction word presented in IF/ID when it is invalid.
- `PC_STEP`, default 4: sequential PC increment in bytes.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `currentPC` in 32: PC register output.
- `newPC` out 32: PC register input; combinational.
- `imem_req` out 1: instruction-memory request.
- `imem_addr` out 32: request address; equals `currentPC`.
- `imem_ack` in 1: response valid; may assert in the same cycle as `imem_req`.
- `imem_rdata` in 32: instruction word; valid when `imem_ack`=1.
- `redirect_valid` in 1: branch/jump taken (from EX).
- `redirect_target` in 32: redirect address.
- `id_stall` in 1: IF/ID must hold its contents.
- `ifid_valid` out 1: IF/ID holds a real instruction.
- `ifid_pc` out 32: PC of the IF/ID instruction.
- `ifid_instr` out 32: IF/ID instruction word.
- `fetch_fault` out 1: misaligned redirect detected (see Configuration).

## Operation
- States: REQ, DROP, HOLD, plus HALT when `FETCH_MISALIGN_CHECK_EN` is defined.
- Registers: `state`, a 32-bit `skid_pc`/`skid_instr` holding buffer, a 32-bit `pend_target`, and the IF/ID register.
- REQ:
  - `imem_req`=1. The request stays asserted and the address stable until ack (`newPC`=`currentPC` while waiting).
  - On ack with no redirect and (`!id_stall`): load IF/ID with {1, currentPC, rdata}; `newPC`=currentPC+PC_STEP.
  - On ack with no redirect and `id_stall`=1: capture the response in skid; `newPC`=currentPC+PC_STEP; go to HOLD.
- Redirect in REQ:
  - Same cycle as ack: discard the data; `newPC`=target.
  - Before ack: store `pend_target`; go to DROP.
- DROP:
  - `imem_req`=1, `newPC`=currentPC until ack.
  - On ack: discard the data; `newPC`=pend_target; go to REQ.
  - A further redirect while in DROP overwrites `pend_target`.
- HOLD:
  - `imem_req`=0, `newPC`=currentPC.
  - When `id_stall`=0: move skid into IF/ID; go to REQ.
  - Redirect: discard skid; `newPC`=target; go to REQ.
- IF/ID update rule, in priority order:
  - `redirect_valid` → `ifid_valid`<=0 and `ifid_instr`<=NOP_INSTR. Redirect overrides `id_stall`.
  - Otherwise `id_stall` → hold.
  - Otherwise load from the response/skid, or `ifid_valid`<=0 (bubble) when nothing is available.
- Arithmetic: PC+PC_STEP wraps modulo 2^32 (32'hFFFFFFFC → 0).
- Priority: `rst` over redirect, redirect over ack, ack over stall.

## Timing
- Reset values:
  - `state`=REQ.
  - `ifid_valid`=0, `ifid_pc`=0, `ifid_instr`=NOP_INSTR.
  - `fetch_fault`=0, skid/pend registers 0.
  - `imem_req`=1 from the first cycle after reset.
- `newPC`, `imem_req` and `imem_addr` are combinational from state, `currentPC`, `imem_ack`, `redirect_*` and `id_stall`.
- Zero-wait memory: one instruction per cycle; IF/ID valid at the edge ending the ack cycle.
- Redirect asserted in cycle N (REQ/HOLD): `imem_addr`=target in cycle N+1. In DROP, the target is issued the cycle after the discarded ack.
- `rst` mid-request drops the outstanding transaction. The memory must also reset on `rst`.

## Configuration
- `FETCH_MISALIGN_CHECK_EN`:
  - Defined: a redirect with target[1:0]≠0 sets `fetch_fault`=1 (sticky until `rst`), flushes IF/ID, and enters HALT. In HALT, `imem_req`=0 and `newPC`=currentPC.
  - Undefined: `fetch_fault` is tied to 0, and the target's low two bits are forced to 0.

## Test plan
- Reset, then zero-wait ack every cycle → `imem_addr` 0,4,8,C; IF/ID PCs 0,4,8 on consecutive cycles; no bubbles.
- Ack latency 3 cycles → `imem_addr` stable at 0 for 3 cycles, `newPC`=0 throughout, then advances to 4; `ifid_valid` low while waiting.
- `id_stall` high at ack of PC 8 → HOLD, `imem_req`=0, IF/ID keeps PC 4; stall drops → IF/ID=PC 8, fetch resumes at C.
- Redirect to 0x100 two cycles into a 3-cycle wait → DROP, ack data discarded, next request at 0x100, `ifid_valid`=0 throughout.
- Redirect and ack same cycle with `id_stall`=1 → IF/ID flushed (NOP), next address = target.
- With `FETCH_MISALIGN_CHECK_EN`: redirect to 0x102 → `fetch_fault`=1 next cycle, `imem_req`=0 until `rst`. Without the macro: fetch at 0x100.
